// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-word pipeline: field layout of the
// packed control word, the bubble value and the EX-stage action encoding.
package ctrl_pkg;

   localparam int CW_WIDTH = 24;

   // Field layout, MSB first. Each field is described by its LSB and width.
   localparam int DINSRC_LSB     = 22;  localparam int DINSRC_W     = 2;
   localparam int REGWE_LSB      = 21;  localparam int REGWE_W      = 1;
   localparam int FPDEST_LSB     = 20;  localparam int FPDEST_W     = 1;
   localparam int REGDEST_LSB    = 18;  localparam int REGDEST_W    = 2;
   localparam int JUMPTYPE_LSB   = 16;  localparam int JUMPTYPE_W   = 2;
   localparam int CONDSRC_LSB    = 15;  localparam int CONDSRC_W    = 1;
   localparam int BRANCHCOND_LSB = 13;  localparam int BRANCHCOND_W = 2;
   localparam int FPSRC_LSB      = 12;  localparam int FPSRC_W      = 1;
   localparam int ALUOP_LSB      = 8;   localparam int ALUOP_W      = 4;
   localparam int ALUCRUFT_LSB   = 7;   localparam int ALUCRUFT_W   = 1;
   localparam int ALUSRC_LSB     = 6;   localparam int ALUSRC_W     = 1;
   localparam int EXTIMM_LSB     = 5;   localparam int EXTIMM_W     = 1;
   localparam int MEMSIZE_LSB    = 3;   localparam int MEMSIZE_W    = 2;
   localparam int MEMWE_LSB      = 2;   localparam int MEMWE_W      = 1;
   localparam int EXTMEM_LSB     = 1;   localparam int EXTMEM_W     = 1;
   localparam int FPUOP_LSB      = 0;   localparam int FPUOP_W      = 1;

   // An empty stage carries this word so no write enable can leak from a bubble.
   localparam logic [CW_WIDTH-1:0] CW_BUBBLE = '0;

   // What the EX stage register does on the coming edge, in priority order.
   typedef enum logic [1:0] {
      EX_FLUSH,
      EX_HOLD,
      EX_LOAD,
      EX_EMPTY
   } exAction_e;

   // Convenience accessors for the two write enables the datapath cares most about.
   function automatic logic cwRegWE(input logic [CW_WIDTH-1:0] cw);
      return cw[REGWE_LSB];
   endfunction

   function automatic logic cwMemWE(input logic [CW_WIDTH-1:0] cw);
      return cw[MEMWE_LSB];
   endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register for a control word and its valid bit.
// Priority: bubble (forced empty) > hold (keep contents) > capture input.
// A captured invalid input also leaves the stage empty with an all-zero word.
module ctrl_stage_reg
   import ctrl_pkg::*;
#(
   parameter int W = CW_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         bubble_i,
   input  logic         hold_i,
   input  logic         valid_i,
   input  logic [W-1:0] cw_i,
   output logic [W-1:0] cw_o,
   output logic         valid_o
);

   logic [W-1:0] cw_q, cw_d;
   logic         valid_q, valid_d;

   // Next-state selection between bubble, hold and capture.
   always_comb begin
      cw_d    = cw_q;
      valid_d = valid_q;
      if (bubble_i) begin
         cw_d    = W'(CW_BUBBLE);
         valid_d = 1'b0;
      end else if (!hold_i) begin
         valid_d = valid_i;
         cw_d    = valid_i ? cw_i : W'(CW_BUBBLE);
      end
   end

   // Stage state register, emptied by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cw_q    <= W'(CW_BUBBLE);
         valid_q <= 1'b0;
      end else begin
         cw_q    <= cw_d;
         valid_q <= valid_d;
      end
   end

   assign cw_o    = cw_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline EX -> MEM -> WB with multi-cycle EX occupancy,
// back-pressure to decode, flush of EX and a retired-instruction counter.
module ctrl_pipe #(
   parameter int CW_WIDTH   = 24,
   parameter int MC_LATENCY = 4,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CW_WIDTH-1:0]  id_cw,
   input  logic                 id_valid,
   input  logic                 id_multi,
   output logic                 id_ready,
   input  logic                 ext_stall,
   input  logic                 flush_ex,
   output logic [CW_WIDTH-1:0]  ex_cw,
   output logic                 ex_valid,
   output logic [CW_WIDTH-1:0]  mem_cw,
   output logic                 mem_valid,
   output logic [CW_WIDTH-1:0]  wb_cw,
   output logic                 wb_valid,
   output logic                 mc_busy,
   output logic [CNT_WIDTH-1:0] retired
);

   import ctrl_pkg::*;

   // Counter must hold MC_LATENCY-1; keep at least one bit when MC_LATENCY is 1.
   localparam int MC_W = (MC_LATENCY > 1) ? $clog2(MC_LATENCY) : 1;
   localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_LATENCY - 1);

   logic [MC_W-1:0]      mcCnt_q, mcCnt_d;
   logic [CNT_WIDTH-1:0] retired_q, retired_d;
   exAction_e            exAction;
   logic                 exAdv;

   assign mc_busy  = ex_valid & (mcCnt_q != '0);
   assign id_ready = !(ext_stall | mc_busy);
   assign exAdv    = ex_valid & id_ready;

   // Decide what EX does this edge and the matching multi-cycle count.
   always_comb begin
      exAction = EX_EMPTY;
      mcCnt_d  = '0;
      if (flush_ex) begin
         exAction = EX_FLUSH;
      end else if (!id_ready) begin
         exAction = EX_HOLD;
      end else if (id_valid) begin
         exAction = EX_LOAD;
      end
      case (exAction)
         EX_HOLD:  mcCnt_d = (mcCnt_q != '0) ? mcCnt_q - 1'b1 : '0;
         EX_LOAD:  mcCnt_d = id_multi ? MC_LOAD : '0;
         default:  mcCnt_d = '0;
      endcase
   end

   // Multi-cycle occupancy counter for the op currently in EX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcCnt_q <= '0;
      end else begin
         mcCnt_q <= mcCnt_d;
      end
   end

   // Retire count advances once per cycle in which WB holds a real instruction.
   always_comb begin
      retired_d = retired_q + CNT_WIDTH'(wb_valid);
   end

   // Retire counter register; wraps naturally at its width.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired_q <= '0;
      end else begin
         retired_q <= retired_d;
      end
   end

   assign retired = retired_q;

   ctrl_stage_reg #(.W(CW_WIDTH)) u_ex (
      .clk      (clk),
      .rst      (rst),
      .bubble_i (exAction == EX_FLUSH),
      .hold_i   (exAction == EX_HOLD),
      .valid_i  (id_valid),
      .cw_i     (id_cw),
      .cw_o     (ex_cw),
      .valid_o  (ex_valid)
   );

   ctrl_stage_reg #(.W(CW_WIDTH)) u_mem (
      .clk      (clk),
      .rst      (rst),
      .bubble_i (1'b0),
      .hold_i   (1'b0),
      .valid_i  (exAdv),
      .cw_i     (ex_cw),
      .cw_o     (mem_cw),
      .valid_o  (mem_valid)
   );

   ctrl_stage_reg #(.W(CW_WIDTH)) u_wb (
      .clk      (clk),
      .rst      (rst),
      .bubble_i (1'b0),
      .hold_i   (1'b0),
      .valid_i  (mem_valid),
      .cw_i     (mem_cw),
      .cw_o     (wb_cw),
      .valid_o  (wb_valid)
   );

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a default instance (MC_LATENCY=4, 32-bit
// counter) and a small instance (MC_LATENCY=1, 4-bit counter) for wrap checks.
module tb_ctrl_pipe;

   logic        clk;
   logic        rst;

   logic [23:0] id_cw;
   logic        id_valid, id_multi, ext_stall, flush_ex;
   logic        id_ready, ex_valid, mem_valid, wb_valid, mc_busy;
   logic [23:0] ex_cw, mem_cw, wb_cw;
   logic [31:0] retired;

   logic [23:0] id_cw2;
   logic        id_valid2, id_multi2;
   logic        id_ready2, ex_valid2, mem_valid2, wb_valid2, mc_busy2;
   logic [23:0] ex_cw2, mem_cw2, wb_cw2;
   logic [3:0]  retired2;

   int vectors;
   int miscompares;
   int stallCycles;

   ctrl_pipe #(.CW_WIDTH(24), .MC_LATENCY(4), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .id_cw(id_cw), .id_valid(id_valid), .id_multi(id_multi),
      .id_ready(id_ready), .ext_stall(ext_stall), .flush_ex(flush_ex),
      .ex_cw(ex_cw), .ex_valid(ex_valid), .mem_cw(mem_cw), .mem_valid(mem_valid),
      .wb_cw(wb_cw), .wb_valid(wb_valid), .mc_busy(mc_busy), .retired(retired)
   );

   ctrl_pipe #(.CW_WIDTH(24), .MC_LATENCY(1), .CNT_WIDTH(4)) dut2 (
      .clk(clk), .rst(rst), .id_cw(id_cw2), .id_valid(id_valid2), .id_multi(id_multi2),
      .id_ready(id_ready2), .ext_stall(1'b0), .flush_ex(1'b0),
      .ex_cw(ex_cw2), .ex_valid(ex_valid2), .mem_cw(mem_cw2), .mem_valid(mem_valid2),
      .wb_cw(wb_cw2), .wb_valid(wb_valid2), .mc_busy(mc_busy2), .retired(retired2)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it, and reports tag/observed/expected on a miss.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive the main instance's inputs (called just after an edge).
   task automatic applyStimulus(input logic [23:0] cw, input logic valid, input logic multi,
                                input logic stall, input logic flush);
      id_cw     = cw;
      id_valid  = valid;
      id_multi  = multi;
      ext_stall = stall;
      flush_ex  = flush;
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Directed sequence.
   initial begin
      vectors     = 0;
      miscompares = 0;
      stallCycles = 0;
      rst = 1'b1;
      applyStimulus(24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      id_cw2 = '0; id_valid2 = 1'b0; id_multi2 = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_ex_valid",  ex_valid,  0);
      checkOutput("rst_mem_valid", mem_valid, 0);
      checkOutput("rst_wb_valid",  wb_valid,  0);
      checkOutput("rst_retired",   retired,   0);
      checkOutput("rst_id_ready",  id_ready,  1);
      rst = 1'b0;

      // Single-cycle stream 1,2,3.
      applyStimulus(24'h000001, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      checkOutput("s_ex_first", ex_cw, 24'h000001);
      applyStimulus(24'h000002, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      checkOutput("s_mem_1", mem_cw, 24'h000001);
      applyStimulus(24'h000003, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      checkOutput("s_wb_1", wb_cw, 24'h000001);
      applyStimulus(24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checkOutput("s_wb_2", wb_cw, 24'h000002);
      checkOutput("s_ex_empty_cw", ex_cw, 0);
      step();
      checkOutput("s_wb_3", wb_cw, 24'h000003);
      checkOutput("s_retired_2", retired, 2);
      step();
      checkOutput("s_retired_3", retired, 3);
      checkOutput("s_wb_drained", wb_valid, 0);

      // Multi-cycle op A followed by B.
      applyStimulus(24'h0000A0, 1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      checkOutput("m_ready_before", id_ready, 1);
      step();
      applyStimulus(24'h0000B0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("m_busy_c1",  mc_busy,  1);
      checkOutput("m_ready_c1", id_ready, 0);
      checkOutput("m_ex_a",     ex_cw,    24'h0000A0);
      step();
      checkOutput("m_busy_c2",  mc_busy,   1);
      checkOutput("m_mem_b1",   mem_valid, 0);
      checkOutput("m_ex_hold",  ex_cw,     24'h0000A0);
      step();
      checkOutput("m_busy_c3",  mc_busy,   1);
      checkOutput("m_mem_b2",   mem_valid, 0);
      step();
      checkOutput("m_busy_end", mc_busy,   0);
      checkOutput("m_ready_end", id_ready, 1);
      checkOutput("m_mem_b3",   mem_valid, 0);
      step();
      checkOutput("m_mem_a",    mem_cw, 24'h0000A0);
      checkOutput("m_ex_b",     ex_cw,  24'h0000B0);

      // ext_stall for two cycles with B in EX.
      applyStimulus(24'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      checkOutput("x_ready_stall", id_ready, 0);
      step();
      checkOutput("x_ex_hold1",  ex_cw,     24'h0000B0);
      checkOutput("x_mem_b1",    mem_valid, 0);
      checkOutput("x_wb_a",      wb_cw,     24'h0000A0);
      step();
      checkOutput("x_ex_hold2",  ex_cw,     24'h0000B0);
      checkOutput("x_mem_b2",    mem_valid, 0);
      checkOutput("x_retired_a", retired,   4);
      applyStimulus(24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checkOutput("x_mem_b",     mem_cw,    24'h0000B0);
      checkOutput("x_ex_empty",  ex_valid,  0);
      step();
      checkOutput("x_wb_b",      wb_cw,     24'h0000B0);

      // Flush while a multi-cycle op is busy and stalled; C sits in MEM.
      applyStimulus(24'h0000C0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      checkOutput("f_retired_b", retired, 5);
      applyStimulus(24'h0000D0, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      checkOutput("f_mem_c",  mem_cw,  24'h0000C0);
      checkOutput("f_busy_d", mc_busy, 1);
      applyStimulus(24'h0000E0, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
      applyStimulus(24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("f_ex_valid", ex_valid, 0);
      checkOutput("f_ex_cw",    ex_cw,    0);
      checkOutput("f_busy",     mc_busy,  0);
      checkOutput("f_ready",    id_ready, 1);
      checkOutput("f_wb_c",     wb_cw,    24'h0000C0);
      checkOutput("f_mem_bub",  mem_valid, 0);
      step();
      checkOutput("f_no_e_ex",  ex_valid, 0);
      checkOutput("f_retired_c", retired, 6);

      // Small instance: 17 multi ops with MC_LATENCY=1 never stall; counter wraps.
      for (int k = 1; k <= 17; k++) begin
         id_cw2    = 24'(k);
         id_valid2 = 1'b1;
         id_multi2 = 1'b1;
         #1;
         if (!id_ready2) stallCycles++;
         step();
      end
      id_valid2 = 1'b0;
      id_multi2 = 1'b0;
      checkOutput("w_no_stall", stallCycles, 0);
      step();
      checkOutput("w_retired_15", retired2, 4'hF);
      step();
      checkOutput("w_retired_wrap0", retired2, 4'h0);
      step();
      checkOutput("w_retired_1", retired2, 4'h1);

      // Reset mid-stream: P, Q single, R multi; reset with R busy (count 2) and Q in WB.
      applyStimulus(24'h000011, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      applyStimulus(24'h000022, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      applyStimulus(24'h000033, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      checkOutput("r_pre_mem", mem_cw, 24'h000022);
      applyStimulus(24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checkOutput("r_pre_busy", mc_busy, 1);
      checkOutput("r_pre_wb",   wb_cw,   24'h000022);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("r_ex_valid", ex_valid, 0);
      checkOutput("r_ex_cw",    ex_cw,    0);
      checkOutput("r_wb_valid", wb_valid, 0);
      checkOutput("r_wb_cw",    wb_cw,    0);
      checkOutput("r_busy",     mc_busy,  0);
      checkOutput("r_retired",  retired,  0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(24'h000077, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      checkOutput("r_first_ex",  ex_cw,    24'h000077);
      checkOutput("r_first_val", ex_valid, 1);
      checkOutput("r_ready",     id_ready, 1);
      applyStimulus(24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) step();
      checkOutput("r_retired_after", retired, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
